// File: rtl/ddr3_dfi_responder.sv
// DFI-side DDR3 target: decodes DFI commands, tracks per-bank open rows,
// stores BL8 write bursts and returns read bursts at a fixed latency.
module ddr3_dfi_responder #(
    parameter int DFI_DQ_WIDTH  = 32,
    parameter int DDR_ROW_BITS  = 13,
    parameter int DDR_COL_BITS  = 10,
    parameter int MEM_ADDR_BITS = 8,
    parameter int READ_LATENCY  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      dfi_cke_i,
    input  logic                      dfi_rst_ni,
    input  logic                      dfi_cs_ni,
    input  logic                      dfi_ras_ni,
    input  logic                      dfi_cas_ni,
    input  logic                      dfi_we_ni,
    input  logic                      dfi_odt_i,
    input  logic [2:0]                dfi_bank_i,
    input  logic [DDR_ROW_BITS-1:0]   dfi_addr_i,
    input  logic                      dfi_wstb_i,
    input  logic                      dfi_wren_i,
    input  logic [DFI_DQ_WIDTH/8-1:0] dfi_mask_i,
    input  logic [DFI_DQ_WIDTH-1:0]   dfi_data_i,
    input  logic                      dfi_rden_i,
    output logic                      dfi_rvld_o,
    output logic                      dfi_last_o,
    output logic [DFI_DQ_WIDTH-1:0]   dfi_data_o,
    output logic [7:0]                bank_open_o,
    output logic                      err_o,
    output logic [7:0]                err_cnt_o
);
    localparam int NUM_BYTES = DFI_DQ_WIDTH / 8;
    localparam int TAG_BITS  = MEM_ADDR_BITS - 2;
    localparam int FULL_BITS = DDR_ROW_BITS + DDR_COL_BITS;
    localparam int DEPTH     = 2 ** MEM_ADDR_BITS;

    logic                     w_act, w_rd, w_wr, w_pre, w_ref;
    logic                     w_bank_open, w_a10, w_ccd_ok;
    logic                     w_rd_ok, w_wr_ok, w_beat_ok, w_pop, w_err;
    logic [DDR_ROW_BITS-1:0]  w_cur_row;
    logic [FULL_BITS-1:0]     w_full;
    logic [TAG_BITS-1:0]      w_tag, w_wtag;
    logic [MEM_ADDR_BITS-1:0] w_waddr, w_raddr;
    logic                     w_emit, w_last, w_bst_active_nxt;
    logic [1:0]               w_bst_beat_nxt;
    logic [TAG_BITS-1:0]      w_bst_base_nxt;
    logic                     w_unused;

    logic [7:0]                r_open;
    logic [DDR_ROW_BITS-1:0]   r_row [8];
    logic [1:0]                r_ccd;
    logic [TAG_BITS-1:0]       r_wf_tag [2];
    logic                      r_wf_rd, r_wf_wr;
    logic [1:0]                r_wf_cnt, r_wbeat;
    logic [DFI_DQ_WIDTH-1:0]   r_mem [DEPTH];
    logic [READ_LATENCY-1:0]   r_dl_v;
    logic [TAG_BITS-1:0]       r_dl_tag [READ_LATENCY];
    logic                      r_bst_active;
    logic [1:0]                r_bst_beat;
    logic [TAG_BITS-1:0]       r_bst_base;
    logic                      r_rvld, r_last, r_err;
    logic [DFI_DQ_WIDTH-1:0]   r_data;
    logic [7:0]                r_err_cnt;

    // Command decode, qualified by cke / rst_n / cs_n
    always_comb begin
        w_act = 1'b0;
        w_rd  = 1'b0;
        w_wr  = 1'b0;
        w_pre = 1'b0;
        w_ref = 1'b0;
        if (dfi_cke_i && dfi_rst_ni && !dfi_cs_ni) begin
            case ({dfi_ras_ni, dfi_cas_ni, dfi_we_ni})
                3'b011:  w_act = 1'b1;
                3'b101:  w_rd  = 1'b1;
                3'b100:  w_wr  = 1'b1;
                3'b010:  w_pre = 1'b1;
                3'b001:  w_ref = 1'b1;
                default: w_act = 1'b0;
            endcase
        end else begin
            w_act = 1'b0;
        end
    end

    // Word address drops col[2:0]; the two low bits carry the beat index
    assign w_bank_open = r_open[dfi_bank_i];
    assign w_cur_row   = r_row[dfi_bank_i];
    assign w_a10       = dfi_addr_i[10];
    assign w_full      = {dfi_bank_i, w_cur_row, dfi_addr_i[DDR_COL_BITS-1:3]};
    assign w_tag       = w_full[TAG_BITS-1:0];
    assign w_ccd_ok    = (r_ccd == 2'd0);
    assign w_rd_ok     = w_rd & w_bank_open & w_ccd_ok;
    assign w_wr_ok     = w_wr & w_bank_open & (r_wf_cnt != 2'd2);
    assign w_beat_ok   = dfi_wren_i & ~reset & ((r_wf_cnt != 2'd0) | w_wr_ok);
    assign w_wtag      = (r_wf_cnt == 2'd0) ? w_tag : r_wf_tag[r_wf_rd];
    assign w_waddr     = {w_wtag, r_wbeat};
    assign w_pop       = w_beat_ok & (r_wbeat == 2'd3);
    assign w_err       = (w_act & w_bank_open) | (w_ref & (|r_open)) |
                         (w_rd & ~w_rd_ok) | (w_wr & ~w_wr_ok) |
                         (dfi_wren_i & ~w_beat_ok);
    assign w_unused    = ^{dfi_wstb_i, dfi_rden_i, dfi_odt_i, w_full};

    // Bank table: open bits and latched rows
    always_ff @(posedge clock) begin
        if (reset) begin
            r_open <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                r_row[i] <= '0;
            end
        end else if (w_act && !w_bank_open) begin
            r_open[dfi_bank_i] <= 1'b1;
            r_row[dfi_bank_i]  <= dfi_addr_i;
        end else if (w_pre) begin
            if (w_a10) begin
                r_open <= 8'd0;
            end else begin
                r_open[dfi_bank_i] <= 1'b0;
            end
        end else if ((w_rd_ok || w_wr_ok) && w_a10) begin
            r_open[dfi_bank_i] <= 1'b0;
        end
    end

    // tCCD guard, read delay line and write-address FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ccd    <= 2'd0;
            r_dl_v   <= '0;
            r_wf_rd  <= 1'b0;
            r_wf_wr  <= 1'b0;
            r_wf_cnt <= 2'd0;
            r_wbeat  <= 2'd0;
        end else begin
            if (w_rd_ok) begin
                r_ccd <= 2'd3;
            end else if (r_ccd != 2'd0) begin
                r_ccd <= r_ccd - 2'd1;
            end
            r_dl_v[0]   <= w_rd_ok;
            r_dl_tag[0] <= w_tag;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_dl_v[i]   <= r_dl_v[i-1];
                r_dl_tag[i] <= r_dl_tag[i-1];
            end
            if (w_wr_ok) begin
                r_wf_tag[r_wf_wr] <= w_tag;
                r_wf_wr           <= ~r_wf_wr;
            end
            if (w_beat_ok) begin
                r_wbeat <= r_wbeat + 2'd1;
            end
            if (w_pop) begin
                r_wf_rd <= ~r_wf_rd;
            end
            r_wf_cnt <= r_wf_cnt + {1'b0, w_wr_ok} - {1'b0, w_pop};
        end
    end

    // Storage: byte-masked writes, never reset
    always_ff @(posedge clock) begin
        if (w_beat_ok) begin
            for (int b = 0; b < NUM_BYTES; b++) begin
                if (!dfi_mask_i[b]) begin
                    r_mem[w_waddr][8*b +: 8] <= dfi_data_i[8*b +: 8];
                end
            end
        end
    end

    // Burst engine: a delay-line arrival starts beat 0, then beats 1..3 follow
    always_comb begin
        w_emit           = 1'b0;
        w_last           = 1'b0;
        w_raddr          = {r_bst_base, r_bst_beat};
        w_bst_active_nxt = r_bst_active;
        w_bst_beat_nxt   = r_bst_beat;
        w_bst_base_nxt   = r_bst_base;
        if (r_dl_v[READ_LATENCY-1]) begin
            w_emit           = 1'b1;
            w_raddr          = {r_dl_tag[READ_LATENCY-1], 2'b00};
            w_bst_active_nxt = 1'b1;
            w_bst_beat_nxt   = 2'd1;
            w_bst_base_nxt   = r_dl_tag[READ_LATENCY-1];
        end else if (r_bst_active) begin
            w_emit           = 1'b1;
            w_last           = (r_bst_beat == 2'd3);
            w_bst_active_nxt = (r_bst_beat != 2'd3);
            w_bst_beat_nxt   = r_bst_beat + 2'd1;
        end else begin
            w_emit = 1'b0;
        end
    end

    // Registered outputs; memory read sees pre-write data on collision
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bst_active <= 1'b0;
            r_bst_beat   <= 2'd0;
            r_bst_base   <= '0;
            r_rvld       <= 1'b0;
            r_last       <= 1'b0;
            r_data       <= '0;
            r_err        <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_bst_active <= w_bst_active_nxt;
            r_bst_beat   <= w_bst_beat_nxt;
            r_bst_base   <= w_bst_base_nxt;
            r_rvld       <= w_emit;
            r_last       <= w_last;
            r_data       <= w_emit ? r_mem[w_raddr] : '0;
            r_err        <= w_err;
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign dfi_rvld_o  = r_rvld;
    assign dfi_last_o  = r_last;
    assign dfi_data_o  = r_data;
    assign bank_open_o = r_open;
    assign err_o       = r_err;
    assign err_cnt_o   = r_err_cnt;
endmodule

// File: tb/tb_ddr3_dfi_responder.sv
// Scoreboard bench for ddr3_dfi_responder: a queue/array reference model predicts
// status and read beats; a monitor compares whatever the DUT presents.
module tb_ddr3_dfi_responder;
    localparam int RB = 13;
    localparam int CB = 10;
    localparam int MB = 8;
    localparam int RL = 4;
    localparam logic [2:0] C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100;
    localparam logic [2:0] C_PRE = 3'b010, C_REF = 3'b001, C_NOP = 3'b111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic cke = 1'b1, rst_n = 1'b1, cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic odt = 1'b0, wstb = 1'b0, wren = 1'b0, rden = 1'b0;
    logic [2:0] bank = 3'd0;
    logic [RB-1:0] addr = '0;
    logic [3:0] mask = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic rvld, rlast, err;
    logic [31:0] rdata;
    logic [7:0] bopen, ecnt;

    always #5 clock = ~clock;

    ddr3_dfi_responder #(.DFI_DQ_WIDTH(32), .DDR_ROW_BITS(RB), .DDR_COL_BITS(CB),
                         .MEM_ADDR_BITS(MB), .READ_LATENCY(RL)) dut (
        .clock(clock), .reset(reset), .dfi_cke_i(cke), .dfi_rst_ni(rst_n),
        .dfi_cs_ni(cs_n), .dfi_ras_ni(ras_n), .dfi_cas_ni(cas_n), .dfi_we_ni(we_n),
        .dfi_odt_i(odt), .dfi_bank_i(bank), .dfi_addr_i(addr), .dfi_wstb_i(wstb),
        .dfi_wren_i(wren), .dfi_mask_i(mask), .dfi_data_i(wdata), .dfi_rden_i(rden),
        .dfi_rvld_o(rvld), .dfi_last_o(rlast), .dfi_data_o(rdata),
        .bank_open_o(bopen), .err_o(err), .err_cnt_o(ecnt));

    int passed = 0;
    int total = 0;
    int edge_n = 0;

    typedef struct { int due; logic [31:0] data; logic last; } beat_t;
    typedef struct { int addr; int due; logic last; } pend_t;
    typedef struct { logic [7:0] bopen; logic err; logic [7:0] cnt; } st_t;
    beat_t exp_q[$];
    pend_t pend[$];
    st_t   st_q[$];

    // Reference model state
    bit          m_open[8];
    int          m_row[8];
    logic [31:0] m_mem[int];
    int          m_fifo[$];
    int          m_beat = 0;
    int          m_last_rd = -100;
    int          m_cnt = 0;

    logic nx_reset = 1'b1, nx_cke = 1'b1, nx_rstn = 1'b1, nx_cs = 1'b0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_n);
    endfunction

    function automatic logic [31:0] mem_rd(int a);
        return m_mem.exists(a) ? m_mem[a] : 32'd0;
    endfunction

    function automatic int word_addr(int b, int col, int beat);
        longint full;
        full = ((longint'(b) * (2 ** RB) + m_row[b]) * (2 ** (CB - 3)) + col / 8) * 4 + beat;
        return int'(full % (2 ** MB));
    endfunction

    // Predict everything the DUT should show after edge k from the inputs now driven
    function automatic void model_step(int k);
        st_t s;
        bit e = 0;
        int col;
        logic [31:0] w;
        if (reset) begin
            foreach (m_open[i]) m_open[i] = 0;
            m_fifo.delete();
            pend.delete();
            m_beat = 0;
            m_last_rd = -100;
            m_cnt = 0;
            s.bopen = 8'd0; s.err = 1'b0; s.cnt = 8'd0;
            st_q.push_back(s);
            return;
        end
        while (pend.size() > 0 && pend[0].due == k) begin
            exp_q.push_back('{k, mem_rd(pend[0].addr), pend[0].last});
            void'(pend.pop_front());
        end
        col = int'(addr) % (2 ** CB);
        if (cke && rst_n && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                C_ACT: if (m_open[bank]) e = 1; else begin m_open[bank] = 1; m_row[bank] = int'(addr); end
                C_PRE: if (addr[10]) begin foreach (m_open[i]) m_open[i] = 0; end else m_open[bank] = 0;
                C_REF: foreach (m_open[i]) if (m_open[i]) e = 1;
                C_RD: begin
                    if (!m_open[bank] || k - m_last_rd < 4) e = 1;
                    else begin
                        m_last_rd = k;
                        for (int b = 0; b < 4; b++) pend.push_back('{word_addr(bank, col, b), k + RL + b, b == 3});
                        if (addr[10]) m_open[bank] = 0;
                    end
                end
                C_WR: begin
                    if (!m_open[bank] || m_fifo.size() == 2) e = 1;
                    else begin
                        m_fifo.push_back(word_addr(bank, col, 0));
                        if (addr[10]) m_open[bank] = 0;
                    end
                end
                default: ;
            endcase
        end
        if (wren) begin
            if (m_fifo.size() == 0) e = 1;
            else begin
                w = mem_rd(m_fifo[0] + m_beat);
                for (int i = 0; i < 4; i++) if (!mask[i]) w[8*i +: 8] = wdata[8*i +: 8];
                m_mem[m_fifo[0] + m_beat] = w;
                m_beat++;
                if (m_beat == 4) begin m_beat = 0; void'(m_fifo.pop_front()); end
            end
        end
        if (e && m_cnt < 255) m_cnt++;
        for (int i = 0; i < 8; i++) s.bopen[i] = m_open[i];
        s.err = e;
        s.cnt = 8'(m_cnt);
        st_q.push_back(s);
    endfunction

    task automatic issue(input logic [2:0] cmd, input int b, input int a, input logic we,
                         input logic [31:0] d, input logic [3:0] m);
        @(negedge clock);
        reset = nx_reset; cke = nx_cke; rst_n = nx_rstn; cs_n = nx_cs;
        {ras_n, cas_n, we_n} = cmd;
        bank = 3'(b); addr = RB'(a); wren = we; wdata = d; mask = m;
        odt = 1'($urandom_range(0, 1)); wstb = we; rden = 1'($urandom_range(0, 1));
        model_step(edge_n + 1);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) issue(C_NOP, 0, 0, 1'b0, 32'd0, 4'd0);
    endtask

    // Monitor: pops expectations whenever the DUT presents status or read beats
    initial begin
        st_t s;
        beat_t x;
        forever begin
            @(posedge clock);
            edge_n++;
            #1;
            if (st_q.size() > 0) begin
                s = st_q.pop_front();
                check("bank_open", {24'd0, bopen}, {24'd0, s.bopen});
                check("err_pulse", {31'd0, err}, {31'd0, s.err});
                check("err_cnt", {24'd0, ecnt}, {24'd0, s.cnt});
            end
            if (rvld) begin
                if (exp_q.size() == 0) check("rvld_spurious", {31'd0, rvld}, 32'd0);
                else begin
                    x = exp_q.pop_front();
                    check("rdata", rdata, x.data);
                    check("rlast", {31'd0, rlast}, {31'd0, x.last});
                    check("rtiming", edge_n, x.due);
                end
            end else begin
                check("rdata_idle", {rdata[31:1], rdata[0] | rlast}, 32'd0);
                if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
                    check("rvld_missing", {31'd0, rvld}, 32'd1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        int r;
        int op;
        nx_reset = 1'b1;
        nop(3);
        nx_reset = 1'b0;
        nop(1);
        // Open bank 0 row 5 and fill every storage word (write beat shares the WRITE cycle)
        issue(C_ACT, 0, 5, 1'b0, 32'd0, 4'd0);
        for (int c = 0; c < 64; c++) begin
            issue(C_WR, 0, c * 8, 1'b1, $urandom, 4'd0);
            for (int b = 1; b < 4; b++) issue(C_NOP, 0, 0, 1'b1, $urandom, 4'd0);
        end
        // Basic write then read
        issue(C_WR, 0, 0, 1'b0, 32'd0, 4'd0);
        issue(C_NOP, 0, 0, 1'b1, 32'h11111111, 4'd0);
        issue(C_NOP, 0, 0, 1'b1, 32'h22222222, 4'd0);
        issue(C_NOP, 0, 0, 1'b1, 32'h33333333, 4'd0);
        issue(C_NOP, 0, 0, 1'b1, 32'h44444444, 4'd0);
        issue(C_RD, 0, 0, 1'b0, 32'd0, 4'd0);
        nop(8);
        // Masked write over 0xAABBCCDD
        issue(C_WR, 0, 8, 1'b0, 32'd0, 4'd0);
        for (int b = 0; b < 4; b++) issue(C_NOP, 0, 0, 1'b1, 32'hAABBCCDD, 4'd0);
        issue(C_WR, 0, 8, 1'b0, 32'd0, 4'd0);
        for (int b = 0; b < 4; b++) issue(C_NOP, 0, 0, 1'b1, 32'h00000000, 4'b1010);
        issue(C_RD, 0, 8, 1'b0, 32'd0, 4'd0);
        nop(8);
        // READs 4 apart (gapless), then 3 apart (second dropped)
        issue(C_RD, 0, 0, 1'b0, 32'd0, 4'd0);
        nop(3);
        issue(C_RD, 0, 8, 1'b0, 32'd0, 4'd0);
        nop(10);
        issue(C_RD, 0, 16, 1'b0, 32'd0, 4'd0);
        nop(2);
        issue(C_RD, 0, 24, 1'b0, 32'd0, 4'd0);
        nop(10);
        // Closed-bank read, double ACT, REF with open banks
        issue(C_RD, 3, 0, 1'b0, 32'd0, 4'd0);
        issue(C_ACT, 1, 9, 1'b0, 32'd0, 4'd0);
        issue(C_ACT, 1, 9, 1'b0, 32'd0, 4'd0);
        issue(C_REF, 0, 0, 1'b0, 32'd0, 4'd0);
        nop(6);
        // Auto-precharge read, then precharge-all
        issue(C_RD, 1, 1024, 1'b0, 32'd0, 4'd0);
        nop(8);
        issue(C_ACT, 2, 1, 1'b0, 32'd0, 4'd0);
        issue(C_ACT, 7, 2, 1'b0, 32'd0, 4'd0);
        issue(C_PRE, 0, 1024, 1'b0, 32'd0, 4'd0);
        nop(3);
        // Reset in the middle of a burst, then reread
        issue(C_ACT, 0, 5, 1'b0, 32'd0, 4'd0);
        issue(C_RD, 0, 0, 1'b0, 32'd0, 4'd0);
        nop(5);
        nx_reset = 1'b1;
        nop(1);
        nx_reset = 1'b0;
        nop(1);
        issue(C_ACT, 0, 5, 1'b0, 32'd0, 4'd0);
        issue(C_RD, 0, 0, 1'b0, 32'd0, 4'd0);
        nop(8);
        // Beat with empty FIFO, WRITE into a full FIFO, then drain and read back
        issue(C_NOP, 0, 0, 1'b1, 32'hDEADBEEF, 4'd0);
        issue(C_WR, 0, 32, 1'b0, 32'd0, 4'd0);
        issue(C_WR, 0, 40, 1'b0, 32'd0, 4'd0);
        issue(C_WR, 0, 48, 1'b0, 32'd0, 4'd0);
        for (int b = 0; b < 8; b++) issue(C_NOP, 0, 0, 1'b1, $urandom, 4'($urandom));
        issue(C_RD, 0, 32, 1'b0, 32'd0, 4'd0);
        nop(3);
        issue(C_RD, 0, 40, 1'b0, 32'd0, 4'd0);
        nop(8);
        // Randomized traffic, including error cases and counter saturation
        for (int i = 0; i < 1200; i++) begin
            nx_cs   = ($urandom_range(0, 15) == 0);
            nx_cke  = ($urandom_range(0, 31) != 0);
            nx_rstn = ($urandom_range(0, 31) != 0);
            nx_reset = ($urandom_range(0, 299) == 0);
            r  = $urandom_range(0, 99);
            op = (r < 18) ? C_ACT : (r < 43) ? C_RD : (r < 63) ? C_WR :
                 (r < 70) ? C_PRE : (r < 74) ? C_REF : (r < 80) ? 3'b000 : C_NOP;
            if (op == C_ACT)
                issue(3'(op), $urandom_range(0, 3), $urandom_range(0, 7),
                      1'($urandom_range(0, 2) == 0), $urandom, 4'($urandom));
            else
                issue(3'(op), $urandom_range(0, 3),
                      $urandom_range(0, 1023) | (($urandom_range(0, 7) == 0) ? 1024 : 0),
                      1'($urandom_range(0, 2) == 0), $urandom, 4'($urandom));
        end
        nx_cs = 1'b0; nx_cke = 1'b1; nx_rstn = 1'b1; nx_reset = 1'b0;
        for (int i = 0; i < 40 && (pend.size() + exp_q.size()) > 0; i++) nop(1);
        nop(2);
        check("drain_empty", pend.size() + exp_q.size(), 32'd0);
        @(posedge clock);
        #3;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
